// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

  // Bits needed for a counter spanning 0..clks-1 (never narrower than one bit).
  function automatic int unsigned bit_cnt_width(input int unsigned clks);
    return (clks <= 32'd1) ? 32'd1 : 32'($clog2(clks));
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read side plus serial line of the UART transmitter.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic                 empty;
  logic                 read;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 tx;
  logic                 busy;

  modport master (input empty, input fifo_data, output read, output tx, output busy);
  modport slave  (output empty, output fifo_data, input read, input tx, input busy);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter; pulses bit_done on the last clock of every serial bit.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned     CNT_W = bit_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)              cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + 1'b1;
  end

  // bit_done is registered but lines up with cnt_q == LAST in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      bit_done <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_done <= !clear && (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls bytes from the FIFO read port and serialises them as 8N1/8N2 frames on tx.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  fifo_uart_tx_if.master bus
);

  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $fatal(1, "fifo_uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
  end

  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 read_q, read_d;
  logic                 busy_q, busy_d;
  logic                 timer_clear;
  logic                 bit_done;

  assign timer_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .bit_done (bit_done)
  );

  // Next-state logic; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;

    unique case (state_q)
      IDLE:  if (!bus.empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = bus.fifo_data;
        state_d = START;
      end
      START: if (bit_done) begin
        state_d = DATA;
        idx_d   = 3'd0;
      end
      DATA: if (bit_done) begin
        if (idx_q == LAST_IDX) begin
          state_d = STOP;
          idx_d   = 3'd0;
          stop_d  = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      STOP: if (bit_done) begin
        if (stop_q == LAST_STOP) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else begin
          stop_d = stop_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    read_d = (state_d == FETCH);
    busy_d = (state_d != IDLE);
    tx_d   = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[idx_d];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= 3'd0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.read = read_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: one FIFO model shared by five transmitter configurations.
module tb_fifo_uart_tx;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model with registered dataout; only the selected DUT sees it non-empty.
  logic [7:0] mem [32];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  int         sel = 0;
  logic       obs_tx, obs_read, obs_busy;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (obs_read && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 5'd1;
    end
  end

  fifo_uart_tx_if if0 ();
  fifo_uart_tx_if if1 ();
  fifo_uart_tx_if if2 ();
  fifo_uart_tx_if if3 ();
  fifo_uart_tx_if if4 ();

  assign if0.empty = fifo_empty || (sel != 0);
  assign if1.empty = fifo_empty || (sel != 1);
  assign if2.empty = fifo_empty || (sel != 2);
  assign if3.empty = fifo_empty || (sel != 3);
  assign if4.empty = fifo_empty || (sel != 4);
  assign if0.fifo_data = fifo_data;
  assign if1.fifo_data = fifo_data;
  assign if2.fifo_data = fifo_data;
  assign if3.fifo_data = fifo_data;
  assign if4.fifo_data = fifo_data;

  fifo_uart_tx #(.CLKS_PER_BIT(4),  .STOP_BITS(1)) dut0 (.clock(clock), .reset_n(reset_n), .bus(if0.master));
  fifo_uart_tx #(.CLKS_PER_BIT(4),  .STOP_BITS(2)) dut1 (.clock(clock), .reset_n(reset_n), .bus(if1.master));
  fifo_uart_tx #(.CLKS_PER_BIT(2),  .STOP_BITS(1)) dut2 (.clock(clock), .reset_n(reset_n), .bus(if2.master));
  fifo_uart_tx #(.CLKS_PER_BIT(3),  .STOP_BITS(1)) dut3 (.clock(clock), .reset_n(reset_n), .bus(if3.master));
  fifo_uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(1)) dut4 (.clock(clock), .reset_n(reset_n), .bus(if4.master));

  always_comb begin
    case (sel)
      1:       begin obs_tx = if1.tx; obs_read = if1.read; obs_busy = if1.busy; end
      2:       begin obs_tx = if2.tx; obs_read = if2.read; obs_busy = if2.busy; end
      3:       begin obs_tx = if3.tx; obs_read = if3.read; obs_busy = if3.busy; end
      4:       begin obs_tx = if4.tx; obs_read = if4.read; obs_busy = if4.busy; end
      default: begin obs_tx = if0.tx; obs_read = if0.read; obs_busy = if0.busy; end
    endcase
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 5'd1;
  endtask

  // Expected line level k cycles after the IDLE cycle that first sees data.
  function automatic logic exp_tx(input int k, input int cpb, input logic [7:0] b);
    int p;
    p = k - 3;
    if (p < 0)       return 1'b1;
    if (p < cpb)     return 1'b0;
    if (p < 9 * cpb) return b[(p - cpb) / cpb];
    return 1'b1;
  endfunction

  // Push n bytes, check every cycle against the frame timing, then decode the line.
  task automatic run_frames(input string tag, input int s, input int cpb, input int sb,
                            input int n, input logic [7:0] b0, input logic [7:0] b1);
    int   period, reads, f, kk, i, mid;
    logic et, er, eb;
    logic [7:0] b, rx;
    logic hist[$];
    sel    = s;
    period = 3 + (9 + sb) * cpb;
    reads  = 0;
    @(negedge clock);
    push(b0);
    if (n > 1) push(b1);
    hist.push_back(obs_tx);
    for (int k = 1; k <= n * period + 2; k++) begin
      @(negedge clock);
      f  = k / period;
      kk = k - f * period;
      b  = (f == 0) ? b0 : b1;
      if (f >= n) begin
        et = 1'b1; er = 1'b0; eb = 1'b0;
      end else begin
        et = exp_tx(kk, cpb, b);
        er = (kk == 1);
        eb = (kk >= 1);
      end
      check({tag, " tx"},   32'(obs_tx),   32'(et));
      check({tag, " read"}, 32'(obs_read), 32'(er));
      check({tag, " busy"}, 32'(obs_busy), 32'(eb));
      if (obs_read) reads++;
      hist.push_back(obs_tx);
    end
    check({tag, " read count"}, 32'(reads), 32'(n));
    // Reference receiver: find a start edge, sample mid-bit, verify the stop bit.
    i = 0;
    for (int fr = 0; fr < n; fr++) begin
      while (i < hist.size() && hist[i] !== 1'b0) i++;
      mid = i + cpb / 2;
      rx  = 8'h00;
      for (int j = 0; j < 8; j++)
        if (mid + cpb * (j + 1) < hist.size()) rx[j] = hist[mid + cpb * (j + 1)];
      check({tag, " rx byte"}, 32'(rx), 32'((fr == 0) ? b0 : b1));
      check({tag, " rx stop"},
            32'((mid + 9 * cpb < hist.size()) ? hist[mid + 9 * cpb] : 1'b0), 32'd1);
      i = mid + 9 * cpb + 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sel     = 0;
    repeat (3) @(negedge clock);
    check("reset tx",   32'(obs_tx),   32'd1);
    check("reset read", 32'(obs_read), 32'd0);
    check("reset busy", 32'(obs_busy), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_frames("single a5", 0, 4, 1, 1, 8'hA5, 8'h00);
    run_frames("b2b 00 ff", 0, 4, 1, 2, 8'h00, 8'hFF);

    // No data offered: line stays idle and nothing is read.
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      check("empty hold", 32'({obs_read, obs_tx, obs_busy}), 32'(3'b010));
    end

    run_frames("stop2 3c", 1, 4, 2, 1, 8'h3C, 8'h00);

    // Reset during data bit 4 of 0x81 (that bit is 0 on the line).
    sel = 0;
    @(negedge clock);
    push(8'h81);
    repeat (24) @(negedge clock);
    check("pre-reset tx", 32'(obs_tx), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("mid-reset tx",   32'(obs_tx),   32'd1);
    check("mid-reset busy", 32'(obs_busy), 32'd0);
    check("mid-reset read", 32'(obs_read), 32'd0);
    repeat (3) begin
      @(negedge clock);
      check("in-reset read", 32'(obs_read), 32'd0);
    end
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("post-reset idle", 32'({obs_read, obs_tx, obs_busy}), 32'(3'b010));
    end
    run_frames("after reset 3c", 0, 4, 1, 1, 8'h3C, 8'h00);

    run_frames("cpb2 55",  2, 2,  1, 1, 8'h55, 8'h00);
    run_frames("cpb3 55",  3, 3,  1, 1, 8'h55, 8'h00);
    run_frames("cpb16 55", 4, 16, 1, 1, 8'h55, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
